// File: rtl/bp_update_ctrl.sv
// In-order branch tracker for the gshare predictor: queues predicted branches,
// matches resolutions against the oldest entry, trains the predictor and recovers on mispredicts.
module bp_update_ctrl #(
   parameter int DEPTH          = 4,
   parameter int RECOVER_CYCLES = 2,
   parameter int CNT_W          = 16
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       alloc_valid,
   input  logic [31:0]                alloc_pc,
   input  logic                       alloc_pred,
   output logic                       alloc_ready,
   input  logic                       res_valid,
   input  logic                       res_taken,
   input  logic [31:0]                res_target,
   output logic                       upd_branch,
   output logic [31:0]                upd_pc,
   output logic                       upd_taken,
   output logic                       mispredict,
   output logic [31:0]                redirect_pc,
   output logic                       flush,
   output logic [$clog2(DEPTH):0]     occupancy,
   output logic [CNT_W-1:0]           br_count,
   output logic [CNT_W-1:0]           mispred_count,
   output logic                       err_underflow
);

   localparam int            AW    = $clog2(DEPTH);
   localparam logic [AW:0]   FULL  = (AW+1)'(DEPTH);
   localparam int            RW    = (RECOVER_CYCLES > 1) ? $clog2(RECOVER_CYCLES) : 1;
   localparam logic [RW-1:0] RLOAD = RW'(RECOVER_CYCLES - 1);

   typedef enum logic {S_RUN, S_RECOVER} state_t;

   logic [31:0]      r_pc [DEPTH];
   logic [DEPTH-1:0] r_pred;
   logic [AW-1:0]    r_head, r_tail;
   logic [AW:0]      r_occ;
   state_t           r_state;
   logic [RW-1:0]    r_rcnt;
   logic             r_ready;
   logic             r_upd_branch, r_upd_taken, r_mispredict, r_flush, r_err;
   logic [31:0]      r_upd_pc, r_redirect_pc;
   logic [CNT_W-1:0] r_br_cnt, r_mis_cnt;

   logic             w_push, w_pop, w_mis;
   logic [31:0]      w_head_pc;
   logic             w_head_pred;
   state_t           w_state_nxt;
   logic [RW-1:0]    w_rcnt_nxt;
   logic [AW:0]      w_occ_nxt;
   logic             w_ready_nxt;

   assign w_head_pc   = r_pc[r_head];
   assign w_head_pred = r_pred[r_head];
   assign w_push      = alloc_valid && r_ready;
   assign w_pop       = res_valid && (r_occ != '0);
   assign w_mis       = w_pop && (res_taken != w_head_pred);

   always_comb begin
      w_state_nxt = r_state;
      w_rcnt_nxt  = r_rcnt;
      w_occ_nxt   = r_occ + (AW+1)'(w_push) - (AW+1)'(w_pop);
      if (w_mis) begin
         // Flush wins over a same-cycle alloc: the freshly pushed entry is dropped too.
         w_state_nxt = S_RECOVER;
         w_rcnt_nxt  = RLOAD;
         w_occ_nxt   = '0;
      end else if (r_state == S_RECOVER) begin
         if (r_rcnt == '0) w_state_nxt = S_RUN;
         else              w_rcnt_nxt  = r_rcnt - RW'(1);
      end
      w_ready_nxt = (w_state_nxt == S_RUN) && (w_occ_nxt != FULL);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_RUN;
         r_rcnt  <= '0;
         r_occ   <= '0;
         r_ready <= 1'b1;
      end else begin
         r_state <= w_state_nxt;
         r_rcnt  <= w_rcnt_nxt;
         r_occ   <= w_occ_nxt;
         r_ready <= w_ready_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_pc[r_tail]   <= alloc_pc;
         r_pred[r_tail] <= alloc_pred;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_head        <= '0;
         r_tail        <= '0;
         r_upd_branch  <= 1'b0;
         r_upd_pc      <= '0;
         r_upd_taken   <= 1'b0;
         r_mispredict  <= 1'b0;
         r_flush       <= 1'b0;
         r_redirect_pc <= '0;
         r_br_cnt      <= '0;
         r_mis_cnt     <= '0;
         r_err         <= 1'b0;
      end else begin
         r_upd_branch <= w_pop;
         r_mispredict <= w_mis;
         r_flush      <= w_mis;
         if (w_mis) begin
            r_head <= '0;
            r_tail <= '0;
         end else begin
            if (w_push) r_tail <= r_tail + AW'(1);
            if (w_pop)  r_head <= r_head + AW'(1);
         end
         if (w_pop) begin
            r_upd_pc    <= w_head_pc;
            r_upd_taken <= res_taken;
            if (r_br_cnt != '1) r_br_cnt <= r_br_cnt + CNT_W'(1);
         end
         if (w_mis) begin
            r_redirect_pc <= res_taken ? res_target : (w_head_pc + 32'd4);
            if (r_mis_cnt != '1) r_mis_cnt <= r_mis_cnt + CNT_W'(1);
         end
         if (res_valid && (r_occ == '0)) r_err <= 1'b1;
      end
   end

   assign alloc_ready   = r_ready;
   assign upd_branch    = r_upd_branch;
   assign upd_pc        = r_upd_pc;
   assign upd_taken     = r_upd_taken;
   assign mispredict    = r_mispredict;
   assign redirect_pc   = r_redirect_pc;
   assign flush         = r_flush;
   assign occupancy     = r_occ;
   assign br_count      = r_br_cnt;
   assign mispred_count = r_mis_cnt;
   assign err_underflow = r_err;

endmodule

// File: tb/tb_bp_update_ctrl.sv
// Directed bench for bp_update_ctrl with hand-computed expectations.
module tb_bp_update_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        alloc_valid, alloc_pred, res_valid, res_taken;
   logic [31:0] alloc_pc, res_target;
   logic        alloc_ready, upd_branch, upd_taken, mispredict, flush, err_underflow;
   logic [31:0] upd_pc, redirect_pc;
   logic [2:0]  occupancy;
   logic [15:0] br_count, mispred_count;

   int n_cmp = 0;
   int n_bad = 0;

   bp_update_ctrl #(.DEPTH(4), .RECOVER_CYCLES(2), .CNT_W(16)) dut (
      .clk(clk), .reset(reset),
      .alloc_valid(alloc_valid), .alloc_pc(alloc_pc), .alloc_pred(alloc_pred),
      .alloc_ready(alloc_ready),
      .res_valid(res_valid), .res_taken(res_taken), .res_target(res_target),
      .upd_branch(upd_branch), .upd_pc(upd_pc), .upd_taken(upd_taken),
      .mispredict(mispredict), .redirect_pc(redirect_pc), .flush(flush),
      .occupancy(occupancy), .br_count(br_count), .mispred_count(mispred_count),
      .err_underflow(err_underflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      alloc_valid = 1'b0;
      res_valid   = 1'b0;
   endtask

   logic [31:0] pcs [6];

   initial begin
      reset = 1'b1; alloc_valid = 1'b0; alloc_pc = '0; alloc_pred = 1'b0;
      res_valid = 1'b0; res_taken = 1'b0; res_target = '0;
      step(); step();
      reset = 1'b0;
      step();
      chk("rst_ready", alloc_ready, 1);
      chk("rst_occ", occupancy, 0);
      chk("rst_upd", upd_branch, 0);
      chk("rst_mis", mispredict, 0);
      chk("rst_flush", flush, 0);
      chk("rst_br", br_count, 0);
      chk("rst_mcnt", mispred_count, 0);
      chk("rst_err", err_underflow, 0);

      // correct taken prediction
      alloc_valid = 1; alloc_pc = 32'h100; alloc_pred = 1;
      step(); idle();
      chk("t1_occ1", occupancy, 1);
      res_valid = 1; res_taken = 1; res_target = 32'h200;
      step(); idle();
      chk("t1_upd", upd_branch, 1);
      chk("t1_pc", upd_pc, 32'h100);
      chk("t1_taken", upd_taken, 1);
      chk("t1_mis", mispredict, 0);
      chk("t1_br", br_count, 1);
      chk("t1_occ0", occupancy, 0);
      step();
      chk("t1_upd_once", upd_branch, 0);

      // not-taken mispredict, recovery window
      alloc_valid = 1; alloc_pc = 32'h40; alloc_pred = 1;
      step(); idle();
      res_valid = 1; res_taken = 0; res_target = 32'hDEAD0000;
      step(); idle();
      chk("t2_mis", mispredict, 1);
      chk("t2_flush", flush, 1);
      chk("t2_redir", redirect_pc, 32'h44);
      chk("t2_mcnt", mispred_count, 1);
      chk("t2_rdy0", alloc_ready, 0);
      chk("t2_taken", upd_taken, 0);
      step();
      chk("t2_rdy1", alloc_ready, 0);
      chk("t2_pulse", mispredict, 0);
      step();
      chk("t2_rdy2", alloc_ready, 1);

      // fill to full, dropped fifth alloc, flush with taken redirect
      for (int i = 0; i < 4; i++) begin
         alloc_valid = 1; alloc_pc = 32'h10 * (i + 1); alloc_pred = 0;
         step();
      end
      chk("t3_full", occupancy, 4);
      chk("t3_rdy", alloc_ready, 0);
      alloc_pc = 32'h50;
      step(); idle();
      chk("t3_drop", occupancy, 4);
      res_valid = 1; res_taken = 1; res_target = 32'h80;
      alloc_valid = 1; alloc_pc = 32'h60; alloc_pred = 0;
      step(); idle();
      chk("t3_mis", mispredict, 1);
      chk("t3_redir", redirect_pc, 32'h80);
      chk("t3_occ", occupancy, 0);
      chk("t3_pc", upd_pc, 32'h10);
      chk("t3_mcnt", mispred_count, 2);
      step(); step();
      chk("t3_rdy_back", alloc_ready, 1);

      // refill 6 entries with overlapping pops: pointers wrap, order kept at occupancy 2
      for (int i = 0; i < 6; i++) pcs[i] = 32'h1000 + 32'h10 * i;
      for (int i = 0; i < 6; i++) begin
         alloc_valid = 1; alloc_pc = pcs[i]; alloc_pred = 0;
         res_valid = (i >= 2); res_taken = 0;
         step();
         if (i >= 2) begin
            chk("t4_pc", upd_pc, pcs[i-2]);
            chk("t4_occ", occupancy, 2);
            chk("t4_nomis", mispredict, 0);
         end
      end
      alloc_valid = 0; res_valid = 1; res_taken = 0;
      step();
      chk("t4_pc4", upd_pc, pcs[4]);
      step(); idle();
      chk("t4_pc5", upd_pc, pcs[5]);
      chk("t4_occ0", occupancy, 0);
      chk("t4_br", br_count, 9);

      // resolve while empty, with a simultaneous alloc still accepted
      res_valid = 1; res_taken = 1;
      alloc_valid = 1; alloc_pc = 32'h300; alloc_pred = 1;
      step(); idle();
      chk("t5_noupd", upd_branch, 0);
      chk("t5_err", err_underflow, 1);
      chk("t5_br", br_count, 9);
      chk("t5_occ", occupancy, 1);
      res_valid = 1; res_taken = 1;
      step(); idle();
      chk("t5_pc", upd_pc, 32'h300);
      chk("t5_err_sticky", err_underflow, 1);
      chk("t5_br2", br_count, 10);

      // saturate br_count with back-to-back correct resolves
      alloc_valid = 1; alloc_pc = 32'h500; alloc_pred = 1;
      step();
      res_valid = 1; res_taken = 1;
      for (int i = 0; i < 65525; i++) step();
      chk("t6_sat", br_count, 16'hFFFF);
      step();
      chk("t6_hold", br_count, 16'hFFFF);
      chk("t6_occ", occupancy, 1);

      // reset mid-stream with alloc and resolve still driven
      reset = 1;
      step();
      chk("t7_occ", occupancy, 0);
      chk("t7_br", br_count, 0);
      chk("t7_mcnt", mispred_count, 0);
      chk("t7_upd", upd_branch, 0);
      chk("t7_err", err_underflow, 0);
      chk("t7_mis", mispredict, 0);
      idle();
      reset = 0;
      step();
      chk("t7_rdy", alloc_ready, 1);
      chk("t7_upd2", upd_branch, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/bp_update_ctrl.md
Name: bp_update_ctrl

Overview:
- In-order tracker and update sequencer for the gshare branch predictor.
- Records every predicted branch leaving fetch in a small FIFO, matches execute-stage resolutions against the oldest entry, and drives the predictor's training ports (branch flag, pc, taken).
- Detects mispredictions, issues redirect and flush, and runs a short recovery window. Keeps saturating branch and misprediction statistics.

Parameters:
- DEPTH, 4, in-flight branch entries; power of two, >= 2.
- RECOVER_CYCLES, 2, cycles alloc_ready held low after a mispredict; >= 1.
- CNT_W, 16, statistics counter width.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high.
- alloc_valid  in  1  fetch presents a predicted branch.
- alloc_pc  in  32  branch pc.
- alloc_pred  in  1  predicted taken (predictor output at fetch).
- alloc_ready  out  1  entry accepted when alloc_valid && alloc_ready.
- res_valid  in  1  execute resolves the oldest in-flight branch.
- res_taken  in  1  actual direction.
- res_target  in  32  actual taken target.
- upd_branch  out  1  predictor training strobe.
- upd_pc  out  32  pc being trained.
- upd_taken  out  1  direction being trained.
- mispredict  out  1  one-cycle redirect pulse.
- redirect_pc  out  32  correct next pc; valid with mispredict.
- flush  out  1  one-cycle pulse, same cycle as mispredict; younger pipeline work is killed.
- occupancy  out  clog2(DEPTH)+1  valid entries.
- br_count  out  CNT_W  resolved branches, saturating.
- mispred_count  out  CNT_W  mispredictions, saturating.
- err_underflow  out  1  sticky; set by a resolve while empty.

Behaviour:
- Reset (synchronous, active-high; clock clk):
  - all outputs 0 except alloc_ready, which is 1 in the cycle after reset deasserts;
  - FIFO pointers and occupancy 0; counters 0; err_underflow 0; FSM = RUN.
  - Reset mid-operation discards all entries and any pending pulse.
- FIFO: circular buffer with head/tail pointers wrapping modulo DEPTH. Each entry holds {pc, pred}.
- FSM states:
  - RUN: alloc_ready = (occupancy != DEPTH). A full FIFO gives no same-cycle pass-through, even when a resolve pops that cycle.
  - RECOVER: alloc_ready = 0; a down-counter loaded with RECOVER_CYCLES-1 runs; when it reaches 0, return to RUN next cycle.
  - Transition: RUN -> RECOVER on a mispredicting resolve. RECOVER -> RUN when the counter expires.
- Resolve while occupancy > 0 (cycle N):
  - head entry popped;
  - at N+1: upd_branch=1, upd_pc=head.pc, upd_taken=res_taken;
  - br_count increments, saturating at all-ones.
- Mispredict: condition is res_taken != head.pred. At N+1:
  - mispredict=1, flush=1;
  - redirect_pc = res_target if res_taken, else head.pc + 4 (mod 2^32);
  - mispred_count increments, saturating.
  - The whole FIFO is cleared at N+1 (occupancy=0), including any entry allocated in cycle N. Flush beats alloc.
  - State = RECOVER from N+1.
- Correct prediction: no mispredict or flush; the remaining entries are kept.
- Simultaneous alloc and correct resolve with occupancy > 0: push and pop both occur; occupancy unchanged.
- Resolve with occupancy == 0:
  - ignored (no upd_branch, no counter change);
  - err_underflow set, cleared only by reset;
  - a simultaneous alloc is still accepted.
- Resolve during RECOVER: handled normally. A further mispredict reloads the recovery counter.
- All outputs are registered. Resolve-to-update latency is exactly 1 cycle, and upd_branch is high for at most one cycle per resolve.
- Alloc with alloc_ready=0 is dropped. Fetch must hold the request.

Test Plan:
- Reset, then alloc pc=0x100 pred=1, resolve taken=1 target=0x200 -> at N+1 upd_branch=1, upd_pc=0x100, upd_taken=1; mispredict=0; br_count=1; occupancy=0.
- Alloc pc=0x40 pred=1, resolve taken=0 -> at N+1 mispredict=flush=1, redirect_pc=0x44, mispred_count=1; alloc_ready=0 for 2 cycles, then 1.
- Fill 4 entries (pc 0x10,0x20,0x30,0x40, pred=0); a fifth alloc sees alloc_ready=0. Resolve the first taken=1 target=0x80 -> redirect_pc=0x80, occupancy 0 at N+1, pointers wrap correctly on refill of 6 entries.
- Alloc and correct resolve in the same cycle at occupancy 2 -> occupancy stays 2, head order preserved (next upd_pc equals the second-oldest pc).
- Resolve with FIFO empty -> no upd_branch, err_underflow=1 and stays 1 until reset.
- Preload br_count to all-ones by running 65535 correct resolves, then one more -> br_count stays 0xFFFF. Assert reset mid-stream -> occupancy=0, counters=0, no pulses.
